mem_access_sequencer: RTL and testbench

- Initiator side of the datapath's memory handshake (RAM_enable / RAM_OpCode out, MFC / MSET back).
- Takes one fetch, load or store request at a time from the main control unit.
- Sequences the datapath strobes for each request: MAR load, MDR load, RAM access, IR/MDR/TEMP capture.
- Reports completion, or a memory trap with a tt code that feeds the datapath's TBR tt input.

---
 rtl/mem_access_sequencer_if.sv | 34 +++
 rtl/mem_access_sequencer.sv | 153 +++++++++++++++
 tb/tb_mem_access_sequencer.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/mem_access_sequencer_if.sv
// Request/strobe/RAM handshake bundle between main control, datapath and the
// memory access sequencer.
interface mem_access_sequencer_if;
  logic       req;
  logic [1:0] req_kind;
  logic [5:0] req_op3;
  logic       MFC;
  logic       MSET;
  logic       busy;
  logic       addr_phase;
  logic       data_phase;
  logic       MAR_Enable;
  logic       MDR_Enable;
  logic       MDR_Mux_select;
  logic       TEMP_Enable;
  logic       IR_Enable;
  logic       RAM_enable;
  logic [5:0] RAM_OpCode;
  logic       done;
  logic       mem_trap;
  logic [2:0] tt;

  modport master (
    input  req, req_kind, req_op3, MFC, MSET,
    output busy, addr_phase, data_phase, MAR_Enable, MDR_Enable, MDR_Mux_select,
           TEMP_Enable, IR_Enable, RAM_enable, RAM_OpCode, done, mem_trap, tt
  );

  modport slave (
    output req, req_kind, req_op3, MFC, MSET,
    input  busy, addr_phase, data_phase, MAR_Enable, MDR_Enable, MDR_Mux_select,
           TEMP_Enable, IR_Enable, RAM_enable, RAM_OpCode, done, mem_trap, tt
  );
endinterface

// File: rtl/mem_access_sequencer.sv
// Sequences fetch/load/store memory accesses and reports done or a trap code.
// Define MEM_TIMEOUT_EN to add the MFC wait counter and the timeout trap (tt=010).
module mem_access_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 15,
  parameter logic [5:0]  FETCH_OP3      = 6'b000000
) (
  input logic                    Clk,
  input logic                    Clr,
  mem_access_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_ACCESS, S_CAPTURE, S_FINISH, S_TRAP
  } state_t;

  typedef enum logic [1:0] {
    K_FETCH = 2'b00, K_LOAD = 2'b01, K_STORE = 2'b10, K_NONE = 2'b11
  } kind_t;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  state_t     state_q, state_d;
  kind_t      kind_q, kind_d;
  logic [5:0] op3_q, op3_d;
  logic [2:0] tt_q, tt_d;

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] TimeoutLimit = 8'(TIMEOUT_CYCLES);
  logic [7:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    op3_d   = op3_q;
    tt_d    = tt_q;
`ifdef MEM_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.req && kind_t'(bus.req_kind) != K_NONE) begin
          kind_d  = kind_t'(bus.req_kind);
          op3_d   = (kind_t'(bus.req_kind) == K_FETCH) ? FETCH_OP3 : bus.req_op3;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        state_d = (kind_q == K_STORE) ? S_DATA : S_ACCESS;
`ifdef MEM_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_DATA: begin
        state_d = S_ACCESS;
`ifdef MEM_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_ACCESS: begin
        // MFC is checked first so it beats a timeout landing on the same cycle.
        if (bus.MFC) begin
          if (bus.MSET) begin
            tt_d    = 3'b001;
            state_d = S_TRAP;
          end else begin
            state_d = S_CAPTURE;
          end
        end
`ifdef MEM_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == TimeoutLimit) begin
            tt_d    = 3'b010;
            state_d = S_TRAP;
          end
        end
`endif
      end
      S_CAPTURE: state_d = S_FINISH;
      S_FINISH:  state_d = S_IDLE;
      S_TRAP:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Clr) begin
      state_q <= S_IDLE;
      kind_q  <= K_FETCH;
      op3_q   <= '0;
      tt_q    <= '0;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      op3_q   <= op3_d;
      tt_q    <= tt_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  always_comb begin
    bus.busy           = (state_q != S_IDLE);
    bus.addr_phase     = 1'b0;
    bus.data_phase     = 1'b0;
    bus.MAR_Enable     = 1'b0;
    bus.MDR_Enable     = 1'b0;
    bus.MDR_Mux_select = 1'b0;
    bus.TEMP_Enable    = 1'b0;
    bus.IR_Enable      = 1'b0;
    bus.RAM_enable     = 1'b0;
    bus.RAM_OpCode     = '0;
    bus.done           = 1'b0;
    bus.mem_trap       = 1'b0;
    bus.tt             = tt_q;
    unique case (state_q)
      S_ADDR: begin
        bus.addr_phase = 1'b1;
        bus.MAR_Enable = 1'b1;
      end
      S_DATA: begin
        bus.data_phase = 1'b1;
        bus.MDR_Enable = 1'b1;
      end
      S_ACCESS: begin
        bus.RAM_enable = 1'b1;
        bus.RAM_OpCode = op3_q;
      end
      S_CAPTURE: begin
        // RAM stays enabled so RAM_Out is still valid while it is captured.
        bus.RAM_enable = 1'b1;
        if (kind_q == K_FETCH) begin
          bus.IR_Enable = 1'b1;
        end else if (kind_q == K_LOAD) begin
          bus.MDR_Enable     = 1'b1;
          bus.MDR_Mux_select = 1'b1;
          bus.TEMP_Enable    = 1'b1;
        end
      end
      S_FINISH: bus.done     = 1'b1;
      S_TRAP:   bus.mem_trap = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed and randomized bench for mem_access_sequencer against a per-transaction
// cycle-trace model built from the request kind, MFC wait count and MSET.
module tb_mem_access_sequencer;
  localparam int unsigned TO = 15;
`ifdef MEM_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Clr = 1'b1;
  mem_access_sequencer_if bus ();

  mem_access_sequencer #(.TIMEOUT_CYCLES(TO), .FETCH_OP3(6'b000000)) dut (
    .Clk(Clk),
    .Clr(Clr),
    .bus(bus)
  );

  always #5 Clk = ~Clk;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  logic [2:0]  tt_m     = '0;

  typedef struct {
    logic [19:0] exp;
    logic        mfc;
    logic        mset;
    string       tag;
  } step_t;

  // {busy,addr,data,MAR,MDR,mux,TEMP,IR,RAM_en,opcode[5:0],done,trap,tt[2:0]}
  function automatic logic [19:0] v(input logic busy, addr, data, mar, mdr, mux,
                                    temp, ir, ram, input logic [5:0] opc,
                                    input logic dn, trp, input logic [2:0] ttv);
    return {busy, addr, data, mar, mdr, mux, temp, ir, ram, opc, dn, trp, ttv};
  endfunction

  function automatic logic [19:0] observed();
    return {bus.busy, bus.addr_phase, bus.data_phase, bus.MAR_Enable, bus.MDR_Enable,
            bus.MDR_Mux_select, bus.TEMP_Enable, bus.IR_Enable, bus.RAM_enable,
            bus.RAM_OpCode, bus.done, bus.mem_trap, bus.tt};
  endfunction

  task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [19:0] idle_v();
    return v(0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, tt_m);
  endfunction

  // waits = number of MFC=0 ACCESS cycles before MFC=1.
  task automatic run_txn(input logic [1:0] kind, input logic [5:0] op3,
                         input int unsigned waits, input logic mset);
    step_t       tr[$];
    step_t       s;
    logic [5:0]  opc;
    bit          to;
    int unsigned n_acc;
    opc   = (kind == 2'b00) ? 6'b000000 : op3;
    to    = TO_EN && (waits >= TO);
    n_acc = to ? TO : waits + 1;
    s.mfc = 1'b0;
    s.mset = 1'b0;
    s.exp = v(1, 1, 0, 1, 0, 0, 0, 0, 0, 6'b000000, 0, 0, tt_m);
    s.tag = $sformatf("addr k%0d", kind);
    tr.push_back(s);
    if (kind == 2'b10) begin
      s.exp = v(1, 0, 1, 0, 1, 0, 0, 0, 0, 6'b000000, 0, 0, tt_m);
      s.tag = "data";
      tr.push_back(s);
    end
    for (int unsigned i = 0; i < n_acc; i++) begin
      s.exp  = v(1, 0, 0, 0, 0, 0, 0, 0, 1, opc, 0, 0, tt_m);
      s.mfc  = !to && (i == waits);
      s.mset = s.mfc && mset;
      s.tag  = $sformatf("access k%0d c%0d", kind, i);
      tr.push_back(s);
    end
    s.mfc = 1'b0;
    s.mset = 1'b0;
    if (to || mset) begin
      tt_m  = to ? 3'b010 : 3'b001;
      s.exp = v(1, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 1, tt_m);
      s.tag = $sformatf("trap k%0d", kind);
      tr.push_back(s);
    end else begin
      s.exp = v(1, 0, 0, 0, kind == 2'b01, kind == 2'b01, kind == 2'b01, kind == 2'b00,
                1, 6'b000000, 0, 0, tt_m);
      s.tag = $sformatf("capture k%0d", kind);
      tr.push_back(s);
      s.exp = v(1, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 1, 0, tt_m);
      s.tag = $sformatf("finish k%0d", kind);
      tr.push_back(s);
    end
    s.exp = idle_v();
    s.tag = $sformatf("idle_after k%0d", kind);
    tr.push_back(s);

    bus.req      = 1'b1;
    bus.req_kind = kind;
    bus.req_op3  = op3;
    foreach (tr[i]) begin
      tick();
      // A busy sequencer must ignore whatever main control throws at it.
      bus.req      = 1'($urandom);
      bus.req_kind = 2'($urandom);
      bus.req_op3  = 6'($urandom);
      check(tr[i].tag, observed(), tr[i].exp);
      bus.MFC  = tr[i].mfc;
      bus.MSET = tr[i].mfc ? tr[i].mset : 1'($urandom);
    end
    bus.req  = 1'b0;
    bus.MFC  = 1'b0;
    bus.MSET = 1'b0;
  endtask

  initial begin
    bus.req      = 1'b0;
    bus.req_kind = 2'b00;
    bus.req_op3  = 6'b000000;
    bus.MFC      = 1'b0;
    bus.MSET     = 1'b0;
    Clr          = 1'b1;
    tick();
    tick();
    check("reset", observed(), idle_v());
    Clr = 1'b0;

    bus.req      = 1'b1;
    bus.req_kind = 2'b11;
    tick();
    bus.req = 1'b0;
    check("reserved_kind", observed(), idle_v());

    run_txn(2'b00, 6'h2A, 0, 1'b0);
    run_txn(2'b01, 6'b000010, 3, 1'b0);
    run_txn(2'b10, 6'b000100, 0, 1'b0);
    run_txn(2'b01, 6'b000001, 0, 1'b1);
    run_txn(2'b01, 6'b000000, TO, 1'b0);
    run_txn(2'b00, 6'b000000, TO - 1, 1'b0);
    run_txn(2'b10, 6'b000111, 2, 1'b1);

    for (int r = 0; r < 25; r++) begin
      run_txn(2'($urandom_range(0, 2)), 6'($urandom), $urandom_range(0, TO + 3),
              1'($urandom_range(0, 3) == 0));
    end

    // Abort a load in its second ACCESS cycle.
    bus.req      = 1'b1;
    bus.req_kind = 2'b01;
    bus.req_op3  = 6'b000011;
    tick();
    bus.req = 1'b0;
    check("abort_addr", observed(), v(1, 1, 0, 1, 0, 0, 0, 0, 0, 6'b000000, 0, 0, tt_m));
    tick();
    check("abort_access1", observed(), v(1, 0, 0, 0, 0, 0, 0, 0, 1, 6'b000011, 0, 0, tt_m));
    tick();
    check("abort_access2", observed(), v(1, 0, 0, 0, 0, 0, 0, 0, 1, 6'b000011, 0, 0, tt_m));
    Clr          = 1'b1;
    bus.MFC      = 1'b1;
    bus.req      = 1'b1;
    bus.req_kind = 2'b01;
    tick();
    tt_m = 3'b000;
    bus.MFC = 1'b0;
    check("abort_reset", observed(), idle_v());
    tick();
    check("clr_release_req", observed(), idle_v());
    Clr     = 1'b0;
    bus.req = 1'b0;
    run_txn(2'b01, 6'b001001, 1, 1'b0);
    tick();
    check("final_idle", observed(), idle_v());

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
